rv_alu_pipe: RTL
================

# rv_alu_pipe

Parametrised, elastic integer execute pipeline for the RV32I/RV64I core. It takes decoded R-type and I-type ALU operations with operand values already read, computes the result and NZCV flags, and carries them through a configurable number of register stages. A valid/ready handshake provides backpressure, and a flush input supports branch redirect. It sits between the decode/register-read stage and the memory-access stage.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- STAGES, 2, pipeline register depth; legal values 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all in-flight operations.
- in_valid  in  1  operation present.
- in_ready  out  1  pipeline can accept an operation this cycle.
- in_funct3  in  3  instruction funct3.
- in_alt  in  1  instruction bit 30 (funct7[5]).
- in_is_imm  in  1  1 = I-type (use in_imm as op2); 0 = R-type (use in_rs2).
- in_rs1  in  XLEN  rs1 value.
- in_rs2  in  XLEN  rs2 value.
- in_imm  in  12  instruction[31:20], raw.
- in_rd  in  5  destination register.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_result  out  XLEN  ALU result.
- out_rd  out  5  destination register.
- out_we  out  1  register write enable; 1 iff the op is legal and rd != 0.
- out_illegal  out  1  the funct3/alt combination is reserved.
- out_flags  out  4  {N,Z,C,V}.

## Operation
- op2 selection: in_is_imm ? sign-extend(in_imm) to XLEN : in_rs2.
- Shift amount: op2[log2(XLEN)-1:0].
- Decode by funct3:
  - 000: ADD, or SUB when alt=1 and R-type. ADDI ignores alt.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when alt=1.
  - 110: OR.
  - 111: AND.
- Illegal combinations: alt=1 with funct3 other than 000/101 (R-type), or alt=1 with 001 (I-type). For these: result 0, out_illegal=1, out_we=0, flags 0.
- Flags:
  - N = result[XLEN-1].
  - Z = (result == 0).
  - ADD: C = carry out of bit XLEN-1; V = (a_msb==b_msb) && (r_msb!=a_msb).
  - SUB: C = unsigned borrow (rs1 < op2); V = (a_msb!=b_msb) && (r_msb!=a_msb).
  - All other ops: C = V = 0.
- The result is computed combinationally from the inputs and registered into stage 0. Stages 1..STAGES-1 are pure delay. The output is driven from the last stage.
- Elastic pipeline: stage k loads when it is empty or its contents move on this cycle. Each stage has its own valid bit.
- in_ready = !valid[0] || stage-0 advances. There are no bubbles at full throughput.

## Timing
- Latency: an op accepted at edge t appears on out_valid after STAGES edges, i.e. during cycle t+STAGES.
- Throughput: 1 op/cycle when out_ready is held high.
- Handshake:
  - Transfer occurs when valid && ready at a rising edge.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - in_ready may depend combinationally on out_ready.
- Reset: all valid bits are cleared. out_valid=0, out_result=0, out_rd=0, out_we=0, out_illegal=0, out_flags=0. in_ready=1 in the first cycle after reset.
- Reset asserted mid-operation: all in-flight ops are lost. Nothing is output.
- Flush:
  - Clears all valid bits at the edge. Any in_valid presented that same cycle is not accepted.
  - out_valid=0 in the next cycle.
  - Payload registers need not be cleared.
- rst and flush together: reset wins (same effect).
- Full pipeline with out_ready=0: in_ready=0 and no state changes.

## Configuration
- RV_ALU_FLAGS_EN: when defined, the flag logic and flag pipeline registers are built and out_flags behaves as specified.
- When RV_ALU_FLAGS_EN is undefined, out_flags is tied to 4'b0 and no flag registers exist. All other behaviour is identical.

## Test plan
- ADD overflow, XLEN=32, STAGES=2, out_ready=1: rs1=0x7FFFFFFF, rs2=1 → after 2 cycles result=0x80000000, flags N=1 Z=0 C=0 V=1.
- SUB zero/borrow: rs1=5, rs2=5 → result 0, Z=1 C=0 V=0. Then rs1=3, rs2=5 → result 0xFFFFFFFE, N=1 C=1.
- Immediate ops: SRAI with rs1=0x80000000, imm=0x404 (alt=1, shamt 4) → 0xF8000000. ADDI with rs1=10, imm=0xFFF → 9.
- Backpressure: 6 back-to-back ops with out_ready low for cycles 3–6 → in_ready falls once STAGES ops are held; all 6 results emerge in order with no loss or duplication.
- Flush: 2 ops in flight, flush asserted with in_valid=1 → out_valid=0 the next cycle, nothing from those 3 ops ever appears, and the pipeline accepts again the following cycle.
- Edge cases: rd=0 gives out_we=0; R-type funct3=100 with alt=1 gives out_illegal=1 and result 0. Repeat the ADD test with XLEN=64, STAGES=1, and with RV_ALU_FLAGS_EN undefined (out_flags=0).

Source files
------------

// File: rtl/rv_alu_pipe.sv
// Elastic RV32I/RV64I integer execute pipeline: ALU + NZCV flags, STAGES register stages, valid/ready.
// Optional feature macro: RV_ALU_FLAGS_EN builds the flag logic and flag registers; otherwise out_flags is 0.
module rv_alu_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_alt,
    input  logic            in_is_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [11:0]     in_imm,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal,
    output logic [3:0]      out_flags
);
    localparam int SHW = $clog2(XLEN);
`ifdef RV_ALU_FLAGS_EN
    localparam int SW = XLEN + 1;
    localparam int PW = XLEN + 11;
`else
    localparam int SW = XLEN;
    localparam int PW = XLEN + 7;
`endif

    logic [XLEN-1:0]        op2;
    logic signed [XLEN-1:0] op1_s;
    logic signed [XLEN-1:0] op2_s;
    logic [SHW-1:0]         shamt;
    logic                   is_sub;
    logic                   illegal;
    logic                   alu_we;
    logic [SW-1:0]          sum;
    logic [XLEN-1:0]        alu_res;
    logic [PW-1:0]          alu_pay;

    assign op2     = in_is_imm ? {{(XLEN-12){in_imm[11]}}, in_imm} : in_rs2;
    assign op1_s   = in_rs1;
    assign op2_s   = op2;
    assign shamt   = op2[SHW-1:0];
    assign is_sub  = (in_funct3 == 3'b000) && in_alt && !in_is_imm;
    assign illegal = in_alt && (in_is_imm ? (in_funct3 == 3'b001)
                                          : !((in_funct3 == 3'b000) || (in_funct3 == 3'b101)));
    assign alu_we  = !illegal && (in_rd != 5'd0);
    // SUB reuses the adder as rs1 + ~op2 + 1; the top bit (flags build) is the carry-out.
    assign sum     = SW'(in_rs1) + SW'(is_sub ? ~op2 : op2) + SW'(is_sub);

    always_comb begin
        alu_res = '0;
        case (in_funct3)
            3'b000: alu_res = sum[XLEN-1:0];
            3'b001: alu_res = in_rs1 << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (in_rs1 < op2)};
            3'b100: alu_res = in_rs1 ^ op2;
            3'b101: begin
                if (in_alt) alu_res = $unsigned(op1_s >>> shamt);
                else        alu_res = in_rs1 >> shamt;
            end
            3'b110: alu_res = in_rs1 | op2;
            3'b111: alu_res = in_rs1 & op2;
            default: alu_res = '0;
        endcase
        if (illegal) alu_res = '0;
    end

`ifdef RV_ALU_FLAGS_EN
    logic [3:0] alu_flg;

    always_comb begin
        alu_flg = '0;
        if (!illegal) begin
            alu_flg[3] = alu_res[XLEN-1];
            alu_flg[2] = (alu_res == '0);
            if (in_funct3 == 3'b000) begin
                if (is_sub) begin
                    alu_flg[1] = !sum[XLEN];
                    alu_flg[0] = (in_rs1[XLEN-1] != op2[XLEN-1]) && (alu_res[XLEN-1] != in_rs1[XLEN-1]);
                end else begin
                    alu_flg[1] = sum[XLEN];
                    alu_flg[0] = (in_rs1[XLEN-1] == op2[XLEN-1]) && (alu_res[XLEN-1] != in_rs1[XLEN-1]);
                end
            end
        end
    end

    assign alu_pay = {alu_flg, alu_res, in_rd, alu_we, illegal};
`else
    assign alu_pay = {alu_res, in_rd, alu_we, illegal};
`endif

    // Stage k may load when empty or when its occupant leaves this cycle.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] vld_in;
    logic [STAGES-1:0] rdy;
    logic [PW-1:0]     pay_q   [STAGES];
    logic [PW-1:0]     pay_src [STAGES];

    always_comb begin : ready_chain
        logic acc;
        acc = out_ready;
        rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc    = !vld_q[k] || acc;
            rdy[k] = acc;
        end
    end

    if (STAGES == 1) begin : g_src_one
        assign vld_in     = in_valid;
        assign pay_src[0] = alu_pay;
    end else begin : g_src_many
        assign vld_in     = {vld_q[STAGES-2:0], in_valid};
        assign pay_src[0] = alu_pay;
        for (genvar k = 1; k < STAGES; k++) begin : g_link
            assign pay_src[k] = pay_q[k-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) vld_d[k] = vld_in[k];
        end
        if (flush) vld_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    // Payload carries no reset; outputs are gated by the last valid bit instead.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) pay_q[k] <= pay_src[k];
        end
    end

    logic [PW-1:0] last_pay;
    assign last_pay    = pay_q[STAGES-1];
    assign in_ready    = rdy[0];
    assign out_valid   = vld_q[STAGES-1];
    assign out_result  = out_valid ? last_pay[XLEN+6:7] : '0;
    assign out_rd      = out_valid ? last_pay[6:2] : 5'd0;
    assign out_we      = out_valid && last_pay[1];
    assign out_illegal = out_valid && last_pay[0];
`ifdef RV_ALU_FLAGS_EN
    assign out_flags   = out_valid ? last_pay[PW-1:PW-4] : 4'b0;
`else
    assign out_flags   = 4'b0;
`endif

endmodule
